// File: rtl/sdram_arbiter.sv
// Round-robin arbiter that shares one sdram_controller port between N_PORTS requesters.
// Define SDRAM_ARB_FIXED_PRIORITY_EN for fixed priority, where the lowest requesting index wins.
module sdram_arbiter #(
    parameter int N_PORTS         = 4,
    parameter int BW_PORTS        = 2,
    parameter int BW_BURST_LENGTH = 4,
    parameter int BW_ADDR         = 25,
    parameter int BW_DATA_BLOCK   = 512
) (
    input  logic                                 clock_i,
    input  logic                                 reset_i,
    input  logic [N_PORTS-1:0]                   req_i,
    input  logic [N_PORTS-1:0]                   cmd_i,
    input  logic [N_PORTS*BW_BURST_LENGTH-1:0]   len_i,
    input  logic [N_PORTS*BW_ADDR-1:0]           addr_i,
    input  logic [N_PORTS*BW_DATA_BLOCK-1:0]     wdata_i,
    output logic [N_PORTS-1:0]                   accept_o,
    output logic [N_PORTS-1:0]                   done_o,
    output logic [BW_DATA_BLOCK-1:0]             rdata_o,
    output logic [BW_PORTS-1:0]                  grant_o,
    output logic                                 busy_o,
    output logic                                 ctrl_request_o,
    output logic                                 ctrl_command_o,
    output logic [BW_BURST_LENGTH-1:0]           ctrl_length_o,
    output logic [BW_ADDR-1:0]                   ctrl_address_o,
    output logic [BW_DATA_BLOCK-1:0]             ctrl_data_o,
    input  logic                                 ctrl_ready_i,
    input  logic [BW_DATA_BLOCK-1:0]             ctrl_data_i,
    input  logic                                 ctrl_done_i
);

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    arb_state_t                 state_r, state_s;
    logic [N_PORTS-1:0]         accept_r, accept_s;
    logic [N_PORTS-1:0]         done_r, done_s;
    logic [BW_DATA_BLOCK-1:0]   rdata_r, rdata_s;
    logic [BW_PORTS-1:0]        grant_r, grant_s;
    logic                       busy_r, busy_s;
    logic                       ctrl_request_r, ctrl_request_s;
    logic                       ctrl_command_r, ctrl_command_s;
    logic [BW_BURST_LENGTH-1:0] ctrl_length_r, ctrl_length_s;
    logic [BW_ADDR-1:0]         ctrl_address_r, ctrl_address_s;
    logic [BW_DATA_BLOCK-1:0]   ctrl_data_r, ctrl_data_s;
`ifndef SDRAM_ARB_FIXED_PRIORITY_EN
    logic [BW_PORTS-1:0]        pointer_r, pointer_s;
`endif
    logic [BW_PORTS-1:0]        winner_s;
    logic                       found_s;
    int                         idx_s;

    // Winner search: first requesting port starting from the search base.
    always_comb begin
        winner_s = {BW_PORTS{1'b0}};
        found_s  = 1'b0;
        idx_s    = 0;
        for (int i = 0; i < N_PORTS; i++) begin
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
            idx_s = i;
`else
            idx_s = int'(pointer_r) + i;
            if (idx_s >= N_PORTS) begin
                idx_s = idx_s - N_PORTS;
            end else begin
                idx_s = idx_s;
            end
`endif
            if (!found_s && req_i[idx_s]) begin
                winner_s = BW_PORTS'(idx_s);
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Next-state and next-output logic; all outputs come straight from registers.
    always_comb begin
        state_s        = state_r;
        accept_s       = {N_PORTS{1'b0}};
        done_s         = {N_PORTS{1'b0}};
        rdata_s        = rdata_r;
        grant_s        = grant_r;
        busy_s         = busy_r;
        ctrl_request_s = 1'b0;
        ctrl_command_s = ctrl_command_r;
        ctrl_length_s  = ctrl_length_r;
        ctrl_address_s = ctrl_address_r;
        ctrl_data_s    = ctrl_data_r;
`ifndef SDRAM_ARB_FIXED_PRIORITY_EN
        pointer_s      = pointer_r;
`endif
        case (state_r)
            ARB_IDLE: begin
                if (ctrl_ready_i && found_s) begin
                    accept_s       = N_PORTS'(1) << winner_s;
                    ctrl_request_s = 1'b1;
                    ctrl_command_s = cmd_i[winner_s];
                    ctrl_length_s  = len_i[int'(winner_s)*BW_BURST_LENGTH +: BW_BURST_LENGTH];
                    ctrl_address_s = addr_i[int'(winner_s)*BW_ADDR +: BW_ADDR];
                    ctrl_data_s    = wdata_i[int'(winner_s)*BW_DATA_BLOCK +: BW_DATA_BLOCK];
                    grant_s        = winner_s;
                    busy_s         = 1'b1;
                    state_s        = ARB_ISSUE;
                end else begin
                    state_s        = ARB_IDLE;
                end
            end
            // Controller drops ready one cycle after acceptance, so it is not consulted here.
            ARB_ISSUE: begin
                state_s = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (ctrl_done_i) begin
                    done_s  = N_PORTS'(1) << grant_r;
                    rdata_s = ctrl_data_i;
                    busy_s  = 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIORITY_EN
                    if (int'(grant_r) == N_PORTS - 1) begin
                        pointer_s = {BW_PORTS{1'b0}};
                    end else begin
                        pointer_s = grant_r + BW_PORTS'(1);
                    end
`endif
                    state_s = ARB_IDLE;
                end else begin
                    state_s = ARB_WAIT;
                end
            end
            default: begin
                state_s = ARB_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_r        <= ARB_IDLE;
            accept_r       <= {N_PORTS{1'b0}};
            done_r         <= {N_PORTS{1'b0}};
            rdata_r        <= {BW_DATA_BLOCK{1'b0}};
            grant_r        <= {BW_PORTS{1'b0}};
            busy_r         <= 1'b0;
            ctrl_request_r <= 1'b0;
            ctrl_command_r <= 1'b0;
            ctrl_length_r  <= {BW_BURST_LENGTH{1'b0}};
            ctrl_address_r <= {BW_ADDR{1'b0}};
            ctrl_data_r    <= {BW_DATA_BLOCK{1'b0}};
`ifndef SDRAM_ARB_FIXED_PRIORITY_EN
            pointer_r      <= {BW_PORTS{1'b0}};
`endif
        end else begin
            state_r        <= state_s;
            accept_r       <= accept_s;
            done_r         <= done_s;
            rdata_r        <= rdata_s;
            grant_r        <= grant_s;
            busy_r         <= busy_s;
            ctrl_request_r <= ctrl_request_s;
            ctrl_command_r <= ctrl_command_s;
            ctrl_length_r  <= ctrl_length_s;
            ctrl_address_r <= ctrl_address_s;
            ctrl_data_r    <= ctrl_data_s;
`ifndef SDRAM_ARB_FIXED_PRIORITY_EN
            pointer_r      <= pointer_s;
`endif
        end
    end

    assign accept_o       = accept_r;
    assign done_o         = done_r;
    assign rdata_o        = rdata_r;
    assign grant_o        = grant_r;
    assign busy_o         = busy_r;
    assign ctrl_request_o = ctrl_request_r;
    assign ctrl_command_o = ctrl_command_r;
    assign ctrl_length_o  = ctrl_length_r;
    assign ctrl_address_o = ctrl_address_r;
    assign ctrl_data_o    = ctrl_data_r;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: a per-cycle vector table plus directed multi-cycle sequences.
module tb_sdram_arbiter;

    localparam int N  = 4;
    localparam int BP = 2;
    localparam int BL = 4;
    localparam int BA = 25;
    localparam int BD = 512;

    logic              clock_i = 1'b0;
    logic              reset_i;
    logic [N-1:0]      req_i, cmd_i;
    logic [N*BL-1:0]   len_i;
    logic [N*BA-1:0]   addr_i;
    logic [N*BD-1:0]   wdata_i;
    logic [N-1:0]      accept_o, done_o;
    logic [BD-1:0]     rdata_o;
    logic [BP-1:0]     grant_o;
    logic              busy_o, ctrl_request_o, ctrl_command_o;
    logic [BL-1:0]     ctrl_length_o;
    logic [BA-1:0]     ctrl_address_o;
    logic [BD-1:0]     ctrl_data_o;
    logic              ctrl_ready_i, ctrl_done_i;
    logic [BD-1:0]     ctrl_data_i;

    int checks   = 0;
    int failures = 0;

    always #5 clock_i = ~clock_i;

    sdram_arbiter #(
        .N_PORTS(N), .BW_PORTS(BP), .BW_BURST_LENGTH(BL), .BW_ADDR(BA), .BW_DATA_BLOCK(BD)
    ) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .req_i(req_i), .cmd_i(cmd_i), .len_i(len_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .accept_o(accept_o), .done_o(done_o), .rdata_o(rdata_o), .grant_o(grant_o),
        .busy_o(busy_o), .ctrl_request_o(ctrl_request_o), .ctrl_command_o(ctrl_command_o),
        .ctrl_length_o(ctrl_length_o), .ctrl_address_o(ctrl_address_o), .ctrl_data_o(ctrl_data_o),
        .ctrl_ready_i(ctrl_ready_i), .ctrl_data_i(ctrl_data_i), .ctrl_done_i(ctrl_done_i)
    );

    typedef struct {
        logic [3:0]  req;
        logic        rdy;
        logic        dn;
        logic [31:0] dw;
        logic [3:0]  e_acc;
        logic [3:0]  e_done;
        logic [1:0]  e_grant;
        logic        e_busy;
        logic        e_creq;
        logic        e_ccmd;
        logic [24:0] e_addr;
        logic [31:0] e_rd;
    } vec_t;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock_i);
        @(negedge clock_i);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_ctl"}, {accept_o, done_o, grant_o, busy_o, ctrl_request_o, ctrl_command_o,
                           ctrl_length_o, ctrl_address_o}, 512'd0);
        chk({nm, "_rdata"}, rdata_o, 512'd0);
        chk({nm, "_cdata"}, ctrl_data_o, 512'd0);
    endtask

    // One transaction: wait for accept, drop request, optionally return done two cycles later.
    task automatic txn(input logic [3:0] r, input logic [1:0] eg, input bit do_done);
        logic [3:0] onehot;
        onehot = 4'b0001 << eg;
        req_i = r;
        ctrl_ready_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (|accept_o) break;
        end
        chk("txn_accept", accept_o, onehot);
        chk("txn_grant", grant_o, eg);
        req_i = 4'b0000;
        cycle();
        cycle();
        if (do_done) begin
            ctrl_done_i = 1'b1;
            cycle();
            ctrl_done_i = 1'b0;
            chk("txn_done", done_o, onehot);
            chk("txn_busy", busy_o, 1'b0);
        end
    endtask

    vec_t vt[14];
    logic [1:0] got[5];
    logic [1:0] exp_rr[5];
    int ng;
    int cnt;

    initial begin
        //        req      rdy   dn    dw            acc      done     g      busy  creq  ccmd  addr        rdata
        vt[0]  = '{4'b0100, 1'b1, 1'b0, 32'h0,        4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b1, 25'h400, 32'h0};
        vt[1]  = '{4'b0000, 1'b1, 1'b0, 32'h0,        4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b1, 25'h400, 32'h0};
        vt[2]  = '{4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b1, 25'h400, 32'h0};
        vt[3]  = '{4'b0000, 1'b1, 1'b1, 32'h12345678, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b1, 25'h400, 32'h12345678};
        vt[4]  = '{4'b0000, 1'b1, 1'b0, 32'h0,        4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1, 25'h400, 32'h12345678};
        vt[5]  = '{4'b0001, 1'b0, 1'b0, 32'h0,        4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1, 25'h400, 32'h12345678};
        vt[6]  = '{4'b0001, 1'b0, 1'b0, 32'h0,        4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1, 25'h400, 32'h12345678};
        vt[7]  = '{4'b0001, 1'b1, 1'b0, 32'h0,        4'b0001, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0, 25'h000, 32'h12345678};
        vt[8]  = '{4'b0000, 1'b0, 1'b1, 32'h55555555, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 25'h000, 32'h12345678};
        vt[9]  = '{4'b0000, 1'b0, 1'b1, 32'hCAFEF00D, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 25'h000, 32'hCAFEF00D};
        vt[10] = '{4'b0010, 1'b1, 1'b0, 32'h0,        4'b0010, 4'b0000, 2'd1, 1'b1, 1'b1, 1'b0, 25'h200, 32'hCAFEF00D};
        vt[11] = '{4'b0000, 1'b1, 1'b0, 32'h0,        4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 25'h200, 32'hCAFEF00D};
        vt[12] = '{4'b0000, 1'b1, 1'b1, 32'hDEADBEEF, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0, 25'h200, 32'hDEADBEEF};
        vt[13] = '{4'b0000, 1'b1, 1'b1, 32'h11111111, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 25'h200, 32'hDEADBEEF};

`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
        exp_rr = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        exp_rr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif

        reset_i      = 1'b1;
        req_i        = 4'b0000;
        cmd_i        = 4'b0100;
        len_i        = {4'd9, 4'd0, 4'd7, 4'd5};
        addr_i       = {25'h600, 25'h400, 25'h200, 25'h000};
        for (int p = 0; p < N; p++) begin
            wdata_i[p*BD +: BD] = {16{32'hA0000000 + 32'(p)}};
        end
        ctrl_ready_i = 1'b0;
        ctrl_done_i  = 1'b0;
        ctrl_data_i  = '0;

        repeat (2) @(negedge clock_i);
        check_all_zero("reset");
        reset_i = 1'b0;

        for (int i = 0; i < 14; i++) begin
            req_i        = vt[i].req;
            ctrl_ready_i = vt[i].rdy;
            ctrl_done_i  = vt[i].dn;
            ctrl_data_i  = {16{vt[i].dw}};
            cycle();
            chk($sformatf("v%0d_accept", i), accept_o, vt[i].e_acc);
            chk($sformatf("v%0d_done", i), done_o, vt[i].e_done);
            chk($sformatf("v%0d_grant", i), grant_o, vt[i].e_grant);
            chk($sformatf("v%0d_busy", i), busy_o, vt[i].e_busy);
            chk($sformatf("v%0d_creq", i), ctrl_request_o, vt[i].e_creq);
            chk($sformatf("v%0d_ccmd", i), ctrl_command_o, vt[i].e_ccmd);
            chk($sformatf("v%0d_caddr", i), ctrl_address_o, vt[i].e_addr);
            chk($sformatf("v%0d_rdata", i), rdata_o, {16{vt[i].e_rd}});
            if (i == 0) begin
                chk("v0_clen", ctrl_length_o, 4'd0);
                chk("v0_cdata", ctrl_data_o, {16{32'hA0000002}});
            end
        end
        req_i       = 4'b0000;
        ctrl_done_i = 1'b0;
        ctrl_data_i = '0;

        // All four ports requesting; controller answers 10 cycles after each accept.
        reset_i = 1'b1;
        cycle();
        reset_i = 1'b0;
        req_i        = 4'b1111;
        ctrl_ready_i = 1'b1;
        ng  = 0;
        cnt = -1;
        for (int cyc = 0; cyc < 300 && ng < 5; cyc++) begin
            cycle();
            ctrl_done_i = 1'b0;
            if (|accept_o) begin
                got[ng] = grant_o;
                chk("rr_accept_onehot", accept_o, 4'b0001 << grant_o);
                ng++;
                cnt = 0;
            end else if (cnt >= 0) begin
                cnt++;
                if (cnt == 10) begin
                    ctrl_done_i = 1'b1;
                    cnt = -1;
                end
            end
        end
        chk("rr_grant_count", ng, 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr_grant%0d", k), got[k], exp_rr[k]);
        end
        req_i = 4'b0000;
        cycle();
        cycle();
        ctrl_done_i = 1'b1;
        cycle();
        ctrl_done_i = 1'b0;
        chk("rr_last_done", done_o, 4'b0001);

        // Leave port 2 mid-transaction with a non-zero pointer, then reset asynchronously.
        txn(4'b0100, 2'd2, 1'b1);
        txn(4'b0100, 2'd2, 1'b0);
        chk("wait_busy", busy_o, 1'b1);
        chk("wait_clen", ctrl_length_o, 4'd0);
        chk("wait_caddr", ctrl_address_o, 25'h400);
        #2 reset_i = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clock_i);
        reset_i = 1'b0;
        txn(4'b1001, 2'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
